// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Queue entries carry the fetch PC, the returned word and an address-error flag.
package inst_fetch_queue_pkg;
  localparam int          INST_ADDR_W  = 32;
  localparam int          INST_DATA_W  = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  typedef struct packed {
    logic                   adel;
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_DATA_W-1:0] instr;
  } fq_entry_t;

  function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Instruction bus, redirect and decode handshake bundle.
// The fetch unit uses the master view; the bus/decoder side uses the slave view.
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;

  logic                   inst_req;
  logic [INST_ADDR_W-1:0] inst_addr;
  logic                   inst_addr_ok;
  logic                   inst_data_ok;
  logic [INST_DATA_W-1:0] inst_rdata;
  logic                   redirect;
  logic [INST_ADDR_W-1:0] redirect_pc;
  logic                   validD;
  logic                   readyD;
  logic [INST_DATA_W-1:0] instrD;
  logic [INST_ADDR_W-1:0] pcD;
  logic                   adelD;

  modport master (
    output inst_req, inst_addr, validD, instrD, pcD, adelD,
    input  inst_addr_ok, inst_data_ok, inst_rdata, redirect, redirect_pc, readyD
  );

  modport slave (
    input  inst_req, inst_addr, validD, instrD, pcD, adelD,
    output inst_addr_ok, inst_data_ok, inst_rdata, redirect, redirect_pc, readyD
  );
endinterface

// File: rtl/inst_fetch_queue_fetch_queue.sv
// Circular FIFO of fetched entries with flush; head reads as zero when empty.
module inst_fetch_queue_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output fq_entry_t                head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_W = (AW+1)'(DEPTH);

  fq_entry_t       mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            do_pop_s;
  logic            do_push_s;

  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != FULL_W) || do_pop_s);

  // Pointer and occupancy update; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign count = count_r;
  assign head  = (count_r != '0) ? mem_r[rd_ptr_r] : '0;
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: pipelined SRAM-like requests, in-order response queue, redirect
// handling with stale-response discard, and address-error entries for misaligned PCs.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  inst_fetch_queue_if.master bus
);
  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam int          DW      = 8;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   resp_pc_r;
  logic [31:0]   addr_r;
  logic [CW-1:0] outstanding_r;
  logic [DW-1:0] discard_r;
  logic          halted_r;
  logic          req_r;
  logic          stale_r;

  logic [CW-1:0] count_s;
  fq_entry_t     head_s;
  fq_entry_t     push_data_s;
  logic          push_s;
  logic          acc_s, drop_s, take_s, pop_s;
  logic          aligned_s, credit_ok_s, raise_s, adel_s;
  logic [DW-1:0] discard_redir_s, discard_norm_s;
  logic [CW-1:0] outstanding_nxt_s;

  assign acc_s       = req_r & bus.inst_addr_ok;
  assign drop_s      = bus.inst_data_ok & (discard_r != '0);
  assign take_s      = bus.inst_data_ok & (discard_r == '0) & (outstanding_r != '0);
  assign pop_s       = (count_s != '0) & bus.readyD;
  assign aligned_s   = (fetch_pc_r[1:0] == 2'b00);
  assign credit_ok_s = (({1'b0, count_s} + {1'b0, outstanding_r}) < DEPTH_W);
  assign raise_s     = !bus.redirect & !halted_r & aligned_s & credit_ok_s & !req_r;
  assign adel_s      = !bus.redirect & !halted_r & !aligned_s & (outstanding_r == '0) &
                       (discard_r == '0) & ({1'b0, count_s} < DEPTH_W);

  // Queue push source: a counted bus response or a synthesized address-error entry.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = '0;
    if (take_s) begin
      push_s            = 1'b1;
      push_data_s.adel  = 1'b0;
      push_data_s.pc    = resp_pc_r;
      push_data_s.instr = bus.inst_rdata;
    end else if (adel_s) begin
      push_s            = 1'b1;
      push_data_s.adel  = 1'b1;
      push_data_s.pc    = fetch_pc_r;
      push_data_s.instr = NOP_WORD;
    end else begin
      push_s      = 1'b0;
      push_data_s = '0;
    end
  end

  // On redirect every fetch still owed by the bus becomes a word to throw away.
  always_comb begin
    discard_redir_s   = discard_r + DW'(outstanding_r) + DW'(acc_s) - DW'(drop_s | take_s);
    discard_norm_s    = discard_r + DW'(acc_s & stale_r) - DW'(drop_s);
    outstanding_nxt_s = outstanding_r + CW'(acc_s & !stale_r) - CW'(take_s);
  end

  inst_fetch_queue_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (bus.redirect),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .count     (count_s),
    .head      (head_s)
  );

  // Fetch PC, credit, discard and request-hold state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      addr_r        <= '0;
      outstanding_r <= '0;
      discard_r     <= '0;
      halted_r      <= 1'b0;
      req_r         <= 1'b0;
      stale_r       <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc_r    <= bus.redirect_pc;
      resp_pc_r     <= bus.redirect_pc;
      halted_r      <= 1'b0;
      outstanding_r <= '0;
      discard_r     <= discard_redir_s;
      // A request the bus has not taken yet must stay up; its data is then unwanted.
      req_r         <= req_r & !acc_s;
      stale_r       <= req_r & !acc_s;
    end else begin
      discard_r     <= discard_norm_s;
      outstanding_r <= outstanding_nxt_s;
      if (acc_s && !stale_r) fetch_pc_r <= next_pc(fetch_pc_r);
      if (take_s)            resp_pc_r  <= next_pc(resp_pc_r);
      if (adel_s)            halted_r   <= 1'b1;
      if (acc_s) begin
        req_r   <= 1'b0;
        stale_r <= 1'b0;
      end else if (raise_s) begin
        req_r  <= 1'b1;
        addr_r <= fetch_pc_r;
      end
    end
  end

  assign bus.inst_req  = req_r;
  assign bus.inst_addr = addr_r;
  assign bus.validD    = (count_s != '0);
  assign bus.instrD    = head_s.instr;
  assign bus.pcD       = head_s.pc;
  assign bus.adelD     = head_s.adel;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: a bus responder plus a transaction-level
// model of which fetched words must reach decode, in which order, and when.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic resetn;
  inst_fetch_queue_if bus();

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int ready; } fetch_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic adel; } dec_t;

  fetch_t      resp_q[$];
  dec_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          epoch = 0;
  int          req_epoch = 0;
  int          cyc = 0;
  int          accepts = 0;
  int          p_aok = 100;
  int          p_rdy = 100;
  int          p_dok = 100;
  logic [31:0] exp_pc = RPC;
  logic [31:0] held_addr = 32'h0;
  bit          mis_pending = 1'b0;
  bit          halted_m = 1'b0;
  bit          held = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int inflight(input bit stale);
    int n = 0;
    foreach (resp_q[i]) if ((resp_q[i].epoch != epoch) == stale) n++;
    return n;
  endfunction

  task automatic post_edge_checks();
    chk("validD", bus.validD, exp_q.size() != 0);
    if (exp_q.size() == 0) begin
      chk("pcD_empty", bus.pcD, 32'h0);
      chk("instrD_empty", bus.instrD, 32'h0);
      chk("adelD_empty", bus.adelD, 32'h0);
    end
    if (held) begin
      chk("req_hold", bus.inst_req, 32'h1);
      chk("addr_hold", bus.inst_addr, held_addr);
    end else if (bus.inst_req === 1'b1) begin
      req_epoch = epoch;
      chk("credit", (exp_q.size() + inflight(1'b0)) < 4, 32'h1);
    end
    if ((halted_m || mis_pending) && !held) chk("stopped_noreq", bus.inst_req, 32'h0);
  endtask

  task automatic cycle(input bit redir, input logic [31:0] rpc);
    logic        pre_req, pre_vld, pre_adel;
    logic [31:0] pre_addr, pre_pc, pre_instr;
    int          stale_before;
    bit          acc, dok;
    fetch_t      f;
    dec_t        d;
    bus.redirect     = redir;
    bus.redirect_pc  = rpc;
    bus.inst_addr_ok = ($urandom_range(99) < p_aok);
    bus.readyD       = ($urandom_range(99) < p_rdy);
    dok = (resp_q.size() > 0) && (resp_q[0].ready <= cyc) && ($urandom_range(99) < p_dok);
    bus.inst_data_ok = dok;
    bus.inst_rdata   = dok ? (resp_q[0].addr ^ 32'hFFFF_FFFF) : $urandom;
    pre_req = bus.inst_req;   pre_addr  = bus.inst_addr;
    pre_vld = bus.validD;     pre_pc    = bus.pcD;
    pre_adel = bus.adelD;     pre_instr = bus.instrD;
    stale_before = inflight(1'b1);
    @(posedge clk);
    acc = pre_req && bus.inst_addr_ok;
    if (pre_vld && bus.readyD && !redir && exp_q.size() > 0) begin
      d = exp_q.pop_front();
      chk("pop_pcD", pre_pc, d.pc);
      chk("pop_instrD", pre_instr, d.instr);
      chk("pop_adelD", pre_adel, d.adel);
    end
    if (dok) begin
      f = resp_q.pop_front();
      if (!redir && f.epoch == epoch) exp_q.push_back('{f.addr, f.addr ^ 32'hFFFF_FFFF, 1'b0});
    end
    if (acc) begin
      accepts++;
      if (req_epoch == epoch) begin
        chk("fetch_addr", pre_addr, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      resp_q.push_back('{pre_addr, req_epoch, cyc + 1});
    end
    if (!redir && mis_pending && stale_before == 0) begin
      exp_q.push_back('{exp_pc, 32'h0, 1'b1});
      mis_pending = 1'b0;
      halted_m = 1'b1;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      exp_pc = rpc;
      mis_pending = (rpc[1:0] != 2'b00);
      halted_m = 1'b0;
    end
    held = pre_req && !acc;
    if (held) held_addr = pre_addr;
    cyc++;
    @(negedge clk);
    post_edge_checks();
  endtask

  task automatic step();
    cycle(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.readyD = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    resp_q.delete(); exp_q.delete();
    epoch++; exp_pc = RPC; mis_pending = 1'b0; halted_m = 1'b0; held = 1'b0;
    chk("rst_inst_req", bus.inst_req, 32'h0);
    chk("rst_inst_addr", bus.inst_addr, 32'h0);
    chk("rst_validD", bus.validD, 32'h0);
    chk("rst_pcD", bus.pcD, 32'h0);
    chk("rst_instrD", bus.instrD, 32'h0);
    chk("rst_adelD", bus.adelD, 32'h0);
    // Release reset with a stray response on the bus; nothing is owed, so it is ignored.
    resetn = 1'b1; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1234_5678; bus.readyD = 1'b1;
    @(posedge clk); cyc++; @(negedge clk);
    bus.inst_data_ok = 1'b0;
    chk("stray_dok_validD", bus.validD, 32'h0);
    chk("first_req", bus.inst_req, 32'h1);
    chk("first_addr", bus.inst_addr, RPC);
    req_epoch = epoch;
  endtask

  initial begin
    int a0;
    logic [31:0] rpc;
    bit r;
    @(negedge clk);
    do_reset();

    // straight-line streaming
    p_aok = 100; p_rdy = 100; p_dok = 100;
    repeat (40) step();
    chk("stream_progress", accepts >= 10, 32'h1);

    // decode stalled: credits cap fetches at DEPTH, one pop frees one credit
    do_reset();
    accepts = 0; p_rdy = 0;
    repeat (20) step();
    chk("bp_accepts", accepts, 32'd4);
    chk("bp_req_low", bus.inst_req, 32'h0);
    p_rdy = 100; step(); p_rdy = 0;
    repeat (10) step();
    chk("bp_one_more", accepts, 32'd5);

    // redirect with fetches in flight
    p_rdy = 100; p_dok = 0;
    repeat (6) step();
    chk("redir_inflight", inflight(1'b0) >= 2, 32'h1);
    cycle(1'b1, 32'hBFC0_0100);
    p_dok = 100;
    for (int i = 0; i < 30 && bus.validD !== 1'b1; i++) step();
    chk("redir_first_valid", bus.validD, 32'h1);
    chk("redir_first_pcD", bus.pcD, 32'hBFC0_0100);

    // misaligned target: one address-error entry, then fetch stays stopped
    p_rdy = 0;
    cycle(1'b1, 32'hBFC0_0102);
    repeat (10) step();
    chk("mis_validD", bus.validD, 32'h1);
    chk("mis_adelD", bus.adelD, 32'h1);
    chk("mis_pcD", bus.pcD, 32'hBFC0_0102);
    chk("mis_instrD", bus.instrD, 32'h0);
    chk("mis_noreq", bus.inst_req, 32'h0);
    p_rdy = 100;
    repeat (5) step();
    chk("mis_halt_req", bus.inst_req, 32'h0);
    chk("mis_drained", bus.validD, 32'h0);
    a0 = accepts;
    cycle(1'b1, 32'hBFC0_0200);
    repeat (10) step();
    chk("mis_resume", accepts > a0, 32'h1);

    // request held across a redirect
    p_aok = 0;
    for (int i = 0; i < 10 && bus.inst_req !== 1'b1; i++) step();
    chk("held_req_up", bus.inst_req, 32'h1);
    step();
    cycle(1'b1, 32'hBFC0_0300);
    step();
    p_aok = 100;
    repeat (20) step();

    // random traffic, redirects (some misaligned, some near the top of memory)
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        p_aok = $urandom_range(100, 20);
        p_rdy = $urandom_range(100, 20);
        p_dok = $urandom_range(100, 20);
      end
      r = ($urandom_range(99) < 3);
      case ($urandom_range(3))
        0:       rpc = 32'hFFFF_FFF0;
        1:       rpc = $urandom | 32'h0000_0001;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      cycle(r, rpc);
    end

    // reset with work queued and in flight
    p_aok = 100; p_rdy = 0; p_dok = 100;
    cycle(1'b1, 32'hBFC0_0400);
    for (int i = 0; i < 40 && exp_q.size() < 3; i++) step();
    p_dok = 0;
    repeat (2) step();
    chk("pre_reset_validD", bus.validD, 32'h1);
    do_reset();
    p_rdy = 100; p_dok = 100;
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Producer end of the decode-stage instruction interface.
- Issues pipelined fetches on the SRAM-like instruction bus (req/addr_ok/data_ok) and buffers returned words in order with their PCs in a DEPTH-entry queue.
- Presents {instrD, pcD, adelD} to the main decoder with a valid/ready handshake.
- Handles branch/exception redirects, including discarding stale in-flight responses, and flags misaligned fetch PCs.

Parameters:
- DEPTH, 4: queue entries; power of two, >=2; also caps queued plus outstanding fetches.
- RESET_PC, 32'hBFC0_0000: first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous active-low reset
- inst_req  out  1  fetch request valid
- inst_addr  out  32  fetch address
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  response data valid this cycle (in order)
- inst_rdata  in  32  response word
- redirect  in  1  flush and restart fetch (branch/jump/exception)
- redirect_pc  in  32  new fetch PC
- validD  out  1  queue head valid
- readyD  in  1  decode accepts head
- instrD  out  32  head instruction; 0 when empty
- pcD  out  32  head PC; 0 when empty
- adelD  out  1  head is an address-error entry

Behaviour:
- Reset (clk edge with resetn=0):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Queue count=0, outstanding=0, discard=0, halted=0.
  - All outputs 0.
- Issue:
  - inst_req=1 when all hold: !halted, fetch_pc[1:0]==0, count+outstanding<DEPTH, no request currently held.
  - inst_addr=fetch_pc.
  - Once raised, inst_req and inst_addr are held stable until inst_addr_ok, even across a redirect.
  - On inst_req&inst_addr_ok: fetch_pc+=4, outstanding+=1. A new request may be raised the next cycle.
- Response (inst_data_ok=1):
  - If discard>0: discard-=1, word dropped.
  - Else if outstanding>0: push {resp_pc, inst_rdata, adel=0}, resp_pc+=4, outstanding-=1.
  - Else: ignore.
- Output:
  - validD = count!=0; head fields come from registered storage.
  - Pop on validD&readyD.
  - Push and pop in the same cycle leave count unchanged. The credit rule guarantees no overflow.
- Latency:
  - data_ok at edge t gives validD at t+1.
  - First inst_req is asserted the cycle after resetn rises.
- Misaligned PC (fetch_pc[1:0]!=0):
  - No bus request is issued.
  - When outstanding==0, discard==0 and count<DEPTH: push {fetch_pc, 32'h0, adel=1} and set halted=1.
  - Fetch stays stopped until the next redirect.
- Redirect (highest priority, same edge):
  - count=0 (pops and pushes that cycle are cancelled).
  - fetch_pc=redirect_pc, resp_pc=redirect_pc, halted=0.
  - discard_next = discard + outstanding + (inst_req&inst_addr_ok) - (inst_data_ok & counted response).
  - outstanding_next=0.
  - A request still held without addr_ok adds 1 to discard when it is later accepted (stale flag), then fetch resumes at redirect_pc.
- Back-to-back redirects accumulate discard correctly; discard never underflows.
- Wrap-around: fetch_pc and resp_pc wrap modulo 2^32; queue pointers wrap modulo DEPTH.

Decomposition:
- Shared package/defines header:
  - RESET_PC.
  - NOP word 32'h0.
  - INST_ADDR_W=32, INST_DATA_W=32.
  - Queue entry layout {adel, pc[31:0], instr[31:0]}.
- One sub-module, fetch_queue: circular FIFO with flush, push/pop, count output, combinational head.
- Credit, discard and stale-request logic stay in the top level.

Test Plan:
- Reset release, addr_ok=1, data_ok one cycle after each accept, readyD=1, rdata=addr^32'hFFFF_FFFF -> inst_addr 0xBFC00000, 0xBFC00004, ...; pcD/instrD pairs match in order.
- readyD=0 from the start -> exactly 4 accepts, then inst_req=0. readyD=1 for one cycle -> one pop, one new request at the next sequential PC.
- Two fetches outstanding, redirect to 0xBFC00100 -> next two data_ok words dropped, validD=0 meanwhile, first pcD=0xBFC00100.
- redirect_pc=0xBFC00102 -> no inst_req; one entry with validD=1, adelD=1, pcD=0xBFC00102, instrD=0. Fetch stops until redirect to 0xBFC00200 resumes it.
- inst_addr_ok held low 3 cycles with redirect in cycle 2 -> inst_req/inst_addr stable; its response is discarded; next inst_addr=redirect_pc.
- resetn=0 with 2 outstanding and 3 queued -> validD=0 next cycle, all counters 0; a data_ok arriving after reset with outstanding==0 is ignored.
